// File: rtl/i2s_pkg.sv
// Shared constants and slot encoding for the I2S microphone-array receiver.
package i2s_pkg;

    localparam int unsigned SLOT_BITS_DEFAULT = 32;
    localparam int unsigned DATA_FIRST_BIT    = 1;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock and word-select generator with one-cycle edge-event strobes.
// Events are registered one cycle early so each is high in the cycle whose closing edge is the event.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 32,
    parameter int unsigned SLOT_BITS = SLOT_BITS_DEFAULT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         sck_o,
    output slot_e                        slot_o,
    output logic                         rise_evt_o,
    output logic                         fall_evt_o,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx_o
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = $clog2(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLOT_BITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    slot_e            slot_q, slot_d;
    logic             sck_q, rise_q, fall_q;

    // Divider wrap is the SCK falling edge: advance bit index, flip slot at end of slot.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        slot_d    = slot_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (bit_idx_q == IDX_LAST) begin
                bit_idx_d = '0;
                slot_d    = (slot_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
            end else begin
                bit_idx_d = bit_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            slot_q    <= SLOT_LEFT;
            sck_q     <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            slot_q    <= slot_d;
            sck_q     <= (cnt_d >= CNT_HIGH);
            rise_q    <= (cnt_d == CNT_RISE);
            fall_q    <= (cnt_d == CNT_LAST);
        end
    end

    assign sck_o      = sck_q;
    assign slot_o     = slot_q;
    assign rise_evt_o = rise_q;
    assign fall_evt_o = fall_q;
    assign bit_idx_o  = bit_idx_q;

endmodule

// File: rtl/i2s_mic_array_rx.sv
// Four-microphone I2S receiver: two shared data lines, left samples staged so all four
// channels are presented together with a single-cycle valid strobe.
module i2s_mic_array_rx
    import i2s_pkg::*;
#(
    parameter int unsigned BITS_AUDIO = 24,
    parameter int unsigned CLK_DIV    = 32,
    parameter int unsigned SLOT_BITS  = SLOT_BITS_DEFAULT
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    output logic                         sck_out,
    output logic                         ws_out,
    input  logic                         sd_a_in,
    input  logic                         sd_b_in,
    output logic signed [BITS_AUDIO-1:0] audio_out_1,
    output logic signed [BITS_AUDIO-1:0] audio_out_2,
    output logic signed [BITS_AUDIO-1:0] audio_out_3,
    output logic signed [BITS_AUDIO-1:0] audio_out_4,
    output logic                         valid_out
);

    localparam int unsigned IDX_W = $clog2(SLOT_BITS);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DATA_FIRST_BIT);
    localparam logic [IDX_W-1:0] IDX_LSB   = IDX_W'(BITS_AUDIO);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SLOT_BITS - 1);

    logic             rise_evt, fall_evt;
    logic [IDX_W-1:0] bit_idx;
    slot_e            slot;

    i2s_clk_gen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_clk_gen (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .sck_o      (sck_out),
        .slot_o     (slot),
        .rise_evt_o (rise_evt),
        .fall_evt_o (fall_evt),
        .bit_idx_o  (bit_idx)
    );

    assign ws_out = (slot == SLOT_RIGHT);

    logic                                sd_a_q, sd_b_q;
    logic [BITS_AUDIO-1:0]               shift_a_q, shift_a_d, shift_b_q, shift_b_d;
    logic [1:0][BITS_AUDIO-1:0]          stage_q, stage_d;
    logic [3:0][BITS_AUDIO-1:0]          audio_q, audio_d;
    logic                                load_q, load_d;
    logic                                valid_q, valid_d;
    logic                                in_data;

    assign in_data = (bit_idx >= IDX_FIRST) && (bit_idx <= IDX_LSB);

    // Shift on SCK rising edges inside the data window; right-slot LSB triggers the output load.
    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        stage_d   = stage_q;
        audio_d   = audio_q;
        load_d    = 1'b0;
        valid_d   = 1'b0;
        if (fall_evt && (bit_idx == IDX_LAST)) begin
            shift_a_d = '0;
            shift_b_d = '0;
        end
        if (rise_evt && in_data) begin
            shift_a_d = {shift_a_q[BITS_AUDIO-2:0], sd_a_q};
            shift_b_d = {shift_b_q[BITS_AUDIO-2:0], sd_b_q};
            if (bit_idx == IDX_LSB) begin
                if (slot == SLOT_LEFT) begin
                    stage_d[0] = shift_a_d;
                    stage_d[1] = shift_b_d;
                end else begin
                    load_d = 1'b1;
                end
            end
        end
        if (load_q) begin
            audio_d = {shift_b_q, stage_q[1], shift_a_q, stage_q[0]};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sd_a_q    <= 1'b0;
            sd_b_q    <= 1'b0;
            shift_a_q <= '0;
            shift_b_q <= '0;
            stage_q   <= '0;
            audio_q   <= '0;
            load_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sd_a_q    <= sd_a_in;
            sd_b_q    <= sd_b_in;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            stage_q   <= stage_d;
            audio_q   <= audio_d;
            load_q    <= load_d;
            valid_q   <= valid_d;
        end
    end

    assign audio_out_1 = audio_q[0];
    assign audio_out_2 = audio_q[1];
    assign audio_out_3 = audio_q[2];
    assign audio_out_4 = audio_q[3];
    assign valid_out   = valid_q;

endmodule
